// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at the start edge, held, and committed to HI/LO
// when the busy countdown expires.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [1:0]  mthilo,
  input  logic [1:0]  mfhilo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        res_q, res_calc;
  logic               done;
  logic               op_valid, is_div, mt_en;
  logic [63:0]        acc, prod_s, prod_u;
  logic signed [31:0] sa, sb;
  logic               div_ovf;

  assign op_valid = (mdu_op >= OP_MULT) && (mdu_op <= OP_MSUBU);
  assign is_div   = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  assign busy     = (state_q == RUN);
  assign start    = op_valid && !flush && !busy;
  // A same-cycle start takes priority over the move-to write.
  assign mt_en    = ((mthilo == 2'b01) || (mthilo == 2'b11)) && !flush && !busy && !start;

  assign acc     = {hi_q, lo_q};
  assign sa      = $signed(src_a);
  assign sb      = $signed(src_b);
  assign prod_s  = 64'(sa) * 64'(sb);
  assign prod_u  = 64'(src_a) * 64'(src_b);
  assign div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // Full 64-bit {HI,LO} result for the operation presented this cycle.
  always_comb begin
    res_calc = '0;
    case (mdu_op)
      OP_MULT:  res_calc = prod_s;
      OP_MULTU: res_calc = prod_u;
      OP_MADD:  res_calc = acc + prod_s;
      OP_MADDU: res_calc = acc + prod_u;
      OP_MSUB:  res_calc = acc - prod_s;
      OP_MSUBU: res_calc = acc - prod_u;
      OP_DIV: begin
        if (src_b == 32'd0)  res_calc = {src_a, 32'hFFFF_FFFF};
        else if (div_ovf)    res_calc = {32'd0, 32'h8000_0000};
        else                 res_calc = {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (src_b == 32'd0)  res_calc = {src_a, 32'hFFFF_FFFF};
        else                 res_calc = {src_a % src_b, src_a / src_b};
      end
      default: res_calc = '0;
    endcase
  end

  // Next-state logic: load the countdown on start, commit when it reaches one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held result plus architectural HI/LO; completion and move-to never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (start) res_q <= res_calc;
      if (done) begin
        hi_q <= res_q[63:32];
        lo_q <= res_q[31:0];
      end else if (mt_en) begin
        if (mthilo == 2'b11) hi_q <= src_a;
        else                 lo_q <= src_a;
      end
    end
  end

  // HI/LO read mux for move-from and MUL writeback.
  always_comb begin
    hilo_out = '0;
    case (mfhilo)
      2'b01:   hilo_out = lo_q;
      2'b10:   hilo_out = hi_q;
      default: hilo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with an expected-result scoreboard.
module tb_mult_div_unit;

  localparam logic [3:0] OP_DUM   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [1:0]  mthilo, mfhilo;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        start, busy;
  logic [31:0] hilo_out, hi_q, lo_q;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .mthilo(mthilo), .mfhilo(mfhilo),
    .src_a(src_a), .src_b(src_b), .flush(flush), .start(start), .busy(busy),
    .hilo_out(hilo_out), .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Upstream must never present a move-to together with a starting op.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(start && (mthilo == 2'b01 || mthilo == 2'b11))) else begin
        errors++;
        $error("FAIL same_cycle_mt_start: observed start=%0b mthilo=%b required no overlap", start, mthilo);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mt(input logic [1:0] sel, input logic [31:0] val);
    mthilo = sel;
    src_a  = val;
    @(negedge clk);
    mthilo = 2'b00;
  endtask

  // Issue one op at a negedge, optionally attempt a move-to on its first busy
  // cycle, then count busy cycles and compare against the scoreboard head.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ncyc, input logic [1:0] mt_sel, input logic [31:0] mt_val);
    exp_t e;
    int   cnt;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    #1;
    chk({tag, "_start"}, 64'(start), 64'(1));
    sb.push_back('{hi: ehi, lo: elo, cyc: ncyc});
    @(negedge clk);
    mdu_op = OP_DUM;
    mthilo = mt_sel;
    src_a  = mt_val;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
      mthilo = 2'b00;
    end
    e = sb.pop_front();
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(e.cyc));
    chk({tag, "_hi"}, 64'(hi_q), 64'(e.hi));
    chk({tag, "_lo"}, 64'(lo_q), 64'(e.lo));
  endtask

  initial begin
    reset = 1'b1; mdu_op = OP_DUM; mthilo = 2'b00; mfhilo = 2'b00;
    src_a = '0; src_b = '0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_hi", 64'(hi_q), 64'(0));
    chk("reset_lo", 64'(lo_q), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 2'b00, 32'd0);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 2'b00, 32'd0);

    // Reset in the fourth busy cycle of a DIVU aborts it with HI/LO cleared.
    mdu_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk); mdu_op = OP_DUM;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midrun_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", 64'(busy), 64'(0));
    chk("midrun_reset_hilo", {hi_q, lo_q}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 2'b00, 32'd0);

    run_op("div_neg7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 2'b00, 32'd0);
    run_op("div_7_neg2",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 2'b00, 32'd0);
    run_op("divu_by0",    OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10, 2'b00, 32'd0);
    run_op("div_by0",     OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 2'b00, 32'd0);
    run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 2'b00, 32'd0);

    // Accumulate across the LO/HI carry boundary.
    mt(2'b01, 32'hFFFF_FFFF);
    mt(2'b11, 32'd0);
    chk("mt_setup", {hi_q, lo_q}, 64'h0000_0000_FFFF_FFFF);
    run_op("madd_carry",  OP_MADD,  32'd1, 32'd1, 32'd1, 32'd0, 5, 2'b00, 32'd0);
    run_op("msubu_borrow", OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 5, 2'b00, 32'd0);
    run_op("madd_neg",    OP_MADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFE, 5, 2'b00, 32'd0);
    run_op("msub_negneg", OP_MSUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD, 5, 2'b00, 32'd0);
    run_op("maddu_big",   OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 5, 2'b00, 32'd0);

    // Flush blocks both start and move-to.
    flush = 1'b1; mdu_op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
    #1;
    chk("flush_start", 64'(start), 64'(0));
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hilo", {hi_q, lo_q}, 64'hFFFF_FFFE_FFFF_FFFE);
    mdu_op = OP_DUM;
    mt(2'b11, 32'h0000_ABCD);
    chk("flush_mthi", 64'(hi_q), 64'hFFFF_FFFE);
    flush = 1'b0;

    // Move-to while busy is dropped; HI keeps the op result.
    run_op("mthi_while_busy", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 2'b11, 32'h0000_1234);

    // Out-of-range opcodes behave as DUM.
    mdu_op = 4'hF;
    #1;
    chk("bad_op_start", 64'(start), 64'(0));
    @(negedge clk);
    chk("bad_op_busy", 64'(busy), 64'(0));
    mdu_op = OP_DUM;

    // Readback mux and move-to visibility timing.
    mt(2'b11, 32'hA5A5_A5A5);
    mt(2'b01, 32'h3C3C_3C3C);
    mfhilo = 2'b10; #1; chk("mf_hi", 64'(hilo_out), 64'(32'hA5A5_A5A5));
    mfhilo = 2'b01; #1; chk("mf_lo", 64'(hilo_out), 64'(32'h3C3C_3C3C));
    mfhilo = 2'b00; #1; chk("mf_none", 64'(hilo_out), 64'(0));
    mfhilo = 2'b11; #1; chk("mf_11", 64'(hilo_out), 64'(0));
    @(negedge clk);
    mfhilo = 2'b01; mthilo = 2'b01; src_a = 32'd5;
    #1;
    chk("mtlo_no_bypass", 64'(hilo_out), 64'(32'h3C3C_3C3C));
    @(negedge clk);
    mthilo = 2'b00;
    chk("mtlo_next_cycle", 64'(hilo_out), 64'(5));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
